dsp_diff_accum: RTL

- Downstream consumer of the DSP subtract primitive's width-bit difference `y`.
- Accumulates a programmed number of signed differences into a saturating running sum, then presents the sum on a valid/ready output.
- Used for sum-of-differences and error-integration kernels built on the DSP subtract prim; sits between the subtractor and the result register or consumer.

---
 rtl/dsp_diff_accum_pkg.sv | 10 +
 rtl/dsp_diff_accum_sat_add.sv | 18 +
 rtl/dsp_diff_accum.sv | 59 +++++
 3 files changed

// File: rtl/dsp_diff_accum_pkg.sv
// dsp_diff_accum_pkg: shared state encoding and saturation clamp constants
package dsp_diff_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic logic [47:0] sat_max(input int w);
    return (48'd1 << (w - 1)) - 48'd1;
  endfunction
  function automatic logic [47:0] sat_min(input int w);
    return 48'd0 - (48'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/dsp_diff_accum_sat_add.sv
// sat_add: combinational signed saturating adder with overflow flag
module sat_add
  import dsp_diff_accum_pkg::*;
#(
  parameter int width = 48
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y,
  output logic             ovf
);
  localparam logic [47:0] mx = sat_max(width);
  localparam logic [47:0] mn = sat_min(width);
  logic [width:0] s;
  assign s   = {a[width-1], a} + {b[width-1], b};
  assign ovf = s[width] ^ s[width-1];
  assign y   = ovf ? (s[width] ? mn[width-1:0] : mx[width-1:0]) : s[width-1:0];
endmodule

// File: rtl/dsp_diff_accum.sv
// dsp_diff_accum: saturating accumulation of len signed differences, result on valid/ready
module dsp_diff_accum
  import dsp_diff_accum_pkg::*;
#(
  parameter int width       = 48,
  parameter int count_width = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [count_width-1:0] len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic                   out_sat,
  output logic                   busy
);
  if (width < 1 || width > 48) begin : g_bad_width
    $error("dsp_diff_accum: width must be in 1..48");
  end
  state_t                 state;
  logic [width-1:0]       acc;
  logic [width-1:0]       sum;
  logic [count_width-1:0] remaining;
  logic                   sat;
  logic                   ovf;
  sat_add #(.width(width)) u_add (.a(acc), .b(in_data), .y(sum), .ovf(ovf));
  assign in_ready  = state == ACC;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = acc;
  assign out_sat   = sat;
  always_ff @(posedge clock)
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      sat       <= 1'b0;
    end else if (state == IDLE) begin
      if (start && len != '0) begin
        state     <= ACC;
        remaining <= len;
        acc       <= '0;
        sat       <= 1'b0;
      end
    end else if (state == ACC) begin
      if (in_valid) begin
        acc       <= sum;
        sat       <= sat | ovf;
        remaining <= remaining - 1'b1;
        if (remaining == count_width'(1)) state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
endmodule
